// File: rtl/seven_segment_scan_decoder.sv
// Monitors a multiplexed 4-digit seven-segment bus and recovers the value on each position.
// A pattern is accepted once {anode, Segment} has held for STABLE_CYCLES consecutive samples.
//
// state | meaning
// IDLE  | sampled anode not one-hot, nothing to accept
// COUNT | one-hot anode, waiting for the pattern to stay stable
// HOLD  | current pattern already accepted, waiting for a change
module seven_segment_scan_decoder #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  anode,
   input  logic [6:0]  Segment,
   output logic [15:0] digits,
   output logic [3:0]  digit_valid,
   output logic        frame_done,
   output logic        err_pattern,
   output logic [1:0]  err_digit
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_COUNT = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   logic [10:0]   s_in;
   logic [10:0]   s_reg;
   logic          s_change;
   logic          chg_q;
   logic [CW-1:0] cnt;
   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic          accept;
   logic [3:0]    s_anode;
   logic [6:0]    s_seg;
   logic          one_hot;
   logic [1:0]    pos;
   logic [4:0]    dec;
   logic [3:0]    seen;
   logic [3:0]    seen_or;

   function automatic logic [4:0] decode(input logic [6:0] seg);
      logic [4:0] r;
      case (seg)
         7'b1111110: r = {1'b1, 4'd0};
         7'b0110000: r = {1'b1, 4'd1};
         7'b1101101: r = {1'b1, 4'd2};
         7'b1111001: r = {1'b1, 4'd3};
         7'b0110011: r = {1'b1, 4'd4};
         7'b1011011: r = {1'b1, 4'd5};
         7'b1011111: r = {1'b1, 4'd6};
         7'b1110000: r = {1'b1, 4'd7};
         7'b1111111: r = {1'b1, 4'd8};
         7'b1111011: r = {1'b1, 4'd9};
         default:    r = 5'd0;
      endcase
      return r;
   endfunction

   assign s_in     = {anode, Segment};
   assign s_change = (s_in != s_reg);
   assign s_anode  = s_reg[10:7];
   assign s_seg    = s_reg[6:0];
   assign one_hot  = (s_anode != 4'd0) && ((s_anode & (s_anode - 4'd1)) == 4'd0);
   assign dec      = decode(s_seg);

   always_comb begin
      pos = 2'd0;
      case (s_anode)
         4'b0010: pos = 2'd1;
         4'b0100: pos = 2'd2;
         4'b1000: pos = 2'd3;
         default: pos = 2'd0;
      endcase
   end

   // cnt counts how many samples s_reg has held its current value
   always_ff @(posedge clk) begin
      if (rst) begin
         s_reg <= '0;
         chg_q <= 1'b0;
         cnt   <= '0;
      end else begin
         s_reg <= s_in;
         chg_q <= s_change;
         if (s_change)
            cnt <= CW'(1);
         else if (cnt != CNT_MAX)
            cnt <= cnt + CW'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (one_hot) begin
               if (cnt == CNT_MAX) begin
                  accept    = 1'b1;
                  state_nxt = ST_HOLD;
               end else begin
                  state_nxt = ST_COUNT;
               end
            end
         end
         ST_COUNT: begin
            if (!one_hot) begin
               state_nxt = ST_IDLE;
            end else if (cnt == CNT_MAX) begin
               accept    = 1'b1;
               state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // chg_q distinguishes a fresh pattern even when cnt saturates at 1
            if (chg_q) begin
               if (!one_hot) begin
                  state_nxt = ST_IDLE;
               end else if (cnt == CNT_MAX) begin
                  accept    = 1'b1;
                  state_nxt = ST_HOLD;
               end else begin
                  state_nxt = ST_COUNT;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   assign seen_or = seen | (accept ? s_anode : 4'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         digits      <= '0;
         digit_valid <= '0;
         frame_done  <= 1'b0;
         err_pattern <= 1'b0;
         err_digit   <= '0;
         seen        <= '0;
      end else begin
         frame_done  <= 1'b0;
         err_pattern <= 1'b0;
         if (accept) begin
            if (dec[4]) begin
               digits[{pos, 2'b00} +: 4] <= dec[3:0];
               digit_valid[pos]          <= 1'b1;
            end else begin
               digit_valid[pos] <= 1'b0;
               if (s_seg != 7'd0) begin
                  err_pattern <= 1'b1;
                  err_digit   <= pos;
               end
            end
         end
         // the completing acceptance is absorbed into the frame it finishes
         if (seen_or == 4'hF) begin
            frame_done <= 1'b1;
            seen       <= 4'd0;
         end else begin
            seen <= seen_or;
         end
      end
   end

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Directed bench for seven_segment_scan_decoder at the default STABLE_CYCLES of 4.
module tb_seven_segment_scan_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  anode;
   logic [6:0]  Segment;
   logic [15:0] digits;
   logic [3:0]  digit_valid;
   logic        frame_done;
   logic        err_pattern;
   logic [1:0]  err_digit;

   int n_cmp = 0;
   int n_mis = 0;
   int fd_cnt = 0;
   int ep_cnt = 0;
   int fd0, ep0;

   logic [6:0] seg_code [10];
   logic [3:0] frm_an   [4];
   logic [3:0] frm_val  [4];
   logic [1:0] frm_pos  [4];

   always #5 clk = ~clk;

   seven_segment_scan_decoder dut (
      .clk         (clk),
      .rst         (rst),
      .anode       (anode),
      .Segment     (Segment),
      .digits      (digits),
      .digit_valid (digit_valid),
      .frame_done  (frame_done),
      .err_pattern (err_pattern),
      .err_digit   (err_digit)
   );

   always @(negedge clk) begin
      if (frame_done)  fd_cnt++;
      if (err_pattern) ep_cnt++;
   end

   task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic drive(input logic [3:0] a, input logic [6:0] s);
      anode   = a;
      Segment = s;
   endtask

   initial begin
      seg_code[0] = 7'b1111110; seg_code[1] = 7'b0110000;
      seg_code[2] = 7'b1101101; seg_code[3] = 7'b1111001;
      seg_code[4] = 7'b0110011; seg_code[5] = 7'b1011011;
      seg_code[6] = 7'b1011111; seg_code[7] = 7'b1110000;
      seg_code[8] = 7'b1111111; seg_code[9] = 7'b1111011;
      frm_an[0] = 4'b1000; frm_val[0] = 4'd9; frm_pos[0] = 2'd3;
      frm_an[1] = 4'b0100; frm_val[1] = 4'd4; frm_pos[1] = 2'd2;
      frm_an[2] = 4'b0010; frm_val[2] = 4'd2; frm_pos[2] = 2'd1;
      frm_an[3] = 4'b0001; frm_val[3] = 4'd7; frm_pos[3] = 2'd0;

      // reset with arbitrary inputs
      rst = 1'b1;
      drive(4'b0101, 7'h55);
      tick(2);
      check_val("rst_digits", digits, 16'h0000);
      check_val("rst_valid", {12'd0, digit_valid}, 16'h0000);
      check_val("rst_frame_done", {15'd0, frame_done}, 16'h0000);
      check_val("rst_err_pattern", {15'd0, err_pattern}, 16'h0000);
      check_val("rst_err_digit", {14'd0, err_digit}, 16'h0000);
      rst = 1'b0;
      drive(4'b0000, 7'd0);
      fd0 = fd_cnt;
      ep0 = ep_cnt;
      tick(10);
      check_val("idle_no_frame", 16'(fd_cnt - fd0), 16'd0);
      check_val("idle_no_err", 16'(ep_cnt - ep0), 16'd0);

      // single digit: accepted at the fifth edge
      drive(4'b0001, seg_code[0]);
      tick(4);
      check_val("single_edge4_valid", {12'd0, digit_valid}, 16'h0000);
      tick(1);
      check_val("single_edge5_valid", {12'd0, digit_valid}, 16'h0001);
      check_val("single_edge5_digit", {12'd0, digits[3:0]}, 16'h0000);
      check_val("single_edge5_err", {15'd0, err_pattern}, 16'h0000);
      tick(3);

      // glitch restarts the window in full
      drive(4'b0010, seg_code[4]);
      tick(3);
      drive(4'b0010, seg_code[1]);
      tick(1);
      drive(4'b0010, seg_code[4]);
      tick(4);
      check_val("glitch_edge4_valid", {12'd0, digit_valid}, 16'h0001);
      check_val("glitch_edge4_digits", digits, 16'h0000);
      tick(1);
      check_val("glitch_edge5_digits", digits, 16'h0040);
      check_val("glitch_edge5_valid", {12'd0, digit_valid}, 16'h0003);
      tick(3);

      // full frame after a fresh reset
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      drive(4'b0000, 7'd0);
      tick(2);
      fd0 = fd_cnt;
      for (int i = 0; i < 4; i++) begin
         drive(frm_an[i], seg_code[frm_val[i]]);
         tick(4);
         check_val($sformatf("frame_pre_fd_%0d", i), {15'd0, frame_done}, 16'h0000);
         tick(1);
         check_val($sformatf("frame_fd_%0d", i), {15'd0, frame_done}, (i == 3) ? 16'd1 : 16'd0);
         check_val($sformatf("frame_valid_%0d", i), {15'd0, digit_valid[frm_pos[i]]}, 16'd1);
         tick(3);
      end
      check_val("frame_digits", digits, 16'h9427);
      check_val("frame_valid", {12'd0, digit_valid}, 16'h000F);
      check_val("frame_fd_count", 16'(fd_cnt - fd0), 16'd1);

      // illegal pattern over a prior digit 3
      drive(4'b0010, seg_code[3]);
      tick(8);
      check_val("illegal_prior_digits", digits, 16'h9437);
      ep0 = ep_cnt;
      drive(4'b0010, 7'b1000000);
      tick(5);
      check_val("illegal_err_pulse", {15'd0, err_pattern}, 16'd1);
      check_val("illegal_err_digit", {14'd0, err_digit}, 16'd1);
      check_val("illegal_valid", {12'd0, digit_valid}, 16'h000D);
      check_val("illegal_digits", digits, 16'h9437);
      tick(1);
      check_val("illegal_err_end", {15'd0, err_pattern}, 16'd0);
      check_val("illegal_err_count", 16'(ep_cnt - ep0), 16'd1);

      // blank clears valid without an error
      drive(4'b0001, 7'd0);
      tick(5);
      check_val("blank_valid", {12'd0, digit_valid}, 16'h000C);
      check_val("blank_digits", digits, 16'h9437);
      check_val("blank_no_err", {15'd0, err_pattern}, 16'd0);
      tick(1);

      // multi-hot anode is never accepted
      fd0 = fd_cnt;
      ep0 = ep_cnt;
      drive(4'b0011, seg_code[8]);
      tick(20);
      check_val("multihot_digits", digits, 16'h9437);
      check_val("multihot_valid", {12'd0, digit_valid}, 16'h000C);
      check_val("multihot_no_err", 16'(ep_cnt - ep0), 16'd0);
      check_val("multihot_no_frame", 16'(fd_cnt - fd0), 16'd0);

      // reset mid-count discards progress
      drive(4'b0001, seg_code[8]);
      tick(3);
      check_val("midcount_valid", {12'd0, digit_valid}, 16'h000C);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check_val("midrst_digits", digits, 16'h0000);
      tick(4);
      check_val("postrst_edge4_valid", {12'd0, digit_valid}, 16'h0000);
      tick(1);
      check_val("postrst_edge5_digits", digits, 16'h0008);
      check_val("postrst_edge5_valid", {12'd0, digit_valid}, 16'h0001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
